// File: rtl/clock_reset_sequencer.sv
// ============================================================================
//  Module      : clock_reset_sequencer
//  Description : Drives the MMCM reset, waits for lock with timeout and bounded
//                retries, releases the pixel-domain system reset only after the
//                lock has been stable for a set time, and re-sequences on lock
//                loss. Reports ready / fail / retry / loss status.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int LOSS_CNT_W    = 8
) (
  input  logic                               clk_in,
  input  logic                               reset_n,
  input  logic                               locked,
  input  logic                               restart,
  output logic                               mmcm_reset,
  output logic                               sys_reset,
  output logic                               ready,
  output logic                               fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
  output logic [LOSS_CNT_W-1:0]              loss_count
);

  localparam int RC_W    = $clog2(MAX_RETRIES + 1);
  localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAILED    = 3'd4
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [RC_W-1:0]        r_retry;
  logic [LOSS_CNT_W-1:0]  r_loss;
  logic                   r_lock_meta;
  logic                   r_lock_s;
  logic                   r_mmcm_reset;
  logic                   r_sys_reset;
  logic                   r_ready;
  logic                   r_fail;

  state_t                 w_nxt;
  logic [RC_W-1:0]        w_retry_nxt;
  logic [LOSS_CNT_W-1:0]  w_loss_nxt;
  logic                   w_cnt_clr;

  // Two-flop synchronizer bringing the asynchronous MMCM lock into clk_in
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  // Next-state, retry and loss decisions; restart overrides every other event
  always_comb begin
    w_nxt       = r_state;
    w_retry_nxt = r_retry;
    w_loss_nxt  = r_loss;
    case (r_state)
      S_RESET_PLL: begin
        if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
          w_nxt = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        if (r_lock_s) begin
          w_nxt = S_STABLE;
        end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          w_retry_nxt = r_retry + RC_W'(1);
          w_nxt       = (w_retry_nxt == RC_W'(MAX_RETRIES)) ? S_FAILED : S_RESET_PLL;
        end
      end
      S_STABLE: begin
        // Any dropout restarts the lock wait with a fresh timeout
        if (!r_lock_s) begin
          w_nxt = S_WAIT_LOCK;
        end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          w_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!r_lock_s) begin
          w_loss_nxt  = (r_loss == {LOSS_CNT_W{1'b1}}) ? r_loss : r_loss + LOSS_CNT_W'(1);
          w_retry_nxt = '0;
          w_nxt       = S_RESET_PLL;
        end
      end
      S_FAILED: begin
        w_nxt = S_FAILED;
      end
      default: begin
        w_nxt = S_RESET_PLL;
      end
    endcase
    // A simultaneous lock drop in RUN is still counted via w_loss_nxt above
    if (restart) begin
      w_nxt       = S_RESET_PLL;
      w_retry_nxt = '0;
    end
    w_cnt_clr = restart || (w_nxt != r_state);
  end

  // Sequencer state, shared cycle counter and Moore outputs decoded from next state
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_RESET_PLL;
      r_cnt        <= '0;
      r_retry      <= '0;
      r_loss       <= '0;
      r_mmcm_reset <= 1'b1;
      r_sys_reset  <= 1'b1;
      r_ready      <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_retry <= w_retry_nxt;
      r_loss  <= w_loss_nxt;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if ((r_state == S_RUN) || (r_state == S_FAILED)) begin
        r_cnt <= r_cnt;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_mmcm_reset <= (w_nxt == S_RESET_PLL) || (w_nxt == S_FAILED);
      r_sys_reset  <= (w_nxt != S_RUN);
      r_ready      <= (w_nxt == S_RUN);
      r_fail       <= (w_nxt == S_FAILED);
    end
  end

  assign mmcm_reset  = r_mmcm_reset;
  assign sys_reset   = r_sys_reset;
  assign ready       = r_ready;
  assign fail        = r_fail;
  assign retry_count = r_retry;
  assign loss_count  = r_loss;

endmodule

`default_nettype wire
